// File: rtl/latency_ram.sv
// Word-organised RAM with a programmable access latency and a FREE/BUSY/ACCESS/ERROR
// handshake; illegal requests (dual enable, misaligned, out of range) are reported as ERROR.
module latency_ram #(
   parameter int DEPTH = 1024,
   parameter int LAT   = 2
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] memaddr,
   input  logic [31:0] memstore,
   input  logic        memREN,
   input  logic        memWEN,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] WAIT = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   localparam logic [3:0] CNT_INIT = (LAT > 0) ? 4'(LAT - 1) : 4'd0;

   logic [1:0]    state, state_nxt;
   logic [3:0]    cnt, cnt_nxt;
   logic [65:0]   req, req_nxt, live;
   logic [31:0]   mem [DEPTH];
   logic          en, valid, bad, acc;
   logic [AW-1:0] idx;

   assign live  = {memaddr, memstore, memREN, memWEN};
   assign idx   = memaddr[2 +: AW];
   assign en    = memREN | memWEN;
   assign valid = (memREN ^ memWEN) && (memaddr[1:0] == 2'b00) &&
                  (memaddr[31:2] < 30'(DEPTH));
   assign bad   = en && !valid;

   // IDLE, DONE and ERR share the same input evaluation, so DONE needs no FREE bubble.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      req_nxt   = req;
      acc       = 1'b0;
      if (state == WAIT) begin
         if (!en) begin
            state_nxt = IDLE;
         end else if (bad) begin
            state_nxt = ERR;
         end else if (live != req) begin
            req_nxt = live;
            cnt_nxt = CNT_INIT;
         end else if (cnt == 4'd0) begin
            state_nxt = DONE;
            acc       = 1'b1;
         end else begin
            cnt_nxt = cnt - 4'd1;
         end
      end else begin
         if (bad) begin
            state_nxt = ERR;
         end else if (valid) begin
            if (LAT == 0) begin
               state_nxt = DONE;
               acc       = 1'b1;
            end else begin
               state_nxt = WAIT;
               req_nxt   = live;
               cnt_nxt   = CNT_INIT;
            end
         end else begin
            state_nxt = IDLE;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         req     <= '0;
         ramload <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         req   <= req_nxt;
         if (acc && memREN) ramload <= mem[idx];
      end
   end

   // Reset clears the array too, which also drops any write still waiting in WAIT.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (acc && memWEN) begin
         mem[idx] <= memstore;
      end
   end

   assign ramstate = state;

   always_ff @(posedge CLK) begin
      assert (LAT >= 0 && LAT <= 15) else $error("latency_ram: LAT must be 0..15");
   end
endmodule
